// File: rtl/present_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : present_round_ctrl
// Function : Iterative PRESENT-80 engine, one round per clock, encrypt and
//            decrypt, with valid/ready handshakes on the input and output side.
// Revision : 1.0  initial release
// ============================================================================
module present_round_ctrl #(
    parameter int ROUNDS = 31
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_data,
    input  logic [79:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [4:0]  round_o
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_keyexp = 2'd1;
    localparam logic [1:0] c_st_round  = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;
    localparam logic [4:0] c_ctr_last  = 5'(ROUNDS);
    localparam logic [4:0] c_ctr_first = 5'd1;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h5;  4'h1: return 4'hE;  4'h2: return 4'hF;  4'h3: return 4'h8;
            4'h4: return 4'hC;  4'h5: return 4'h1;  4'h6: return 4'h2;  4'h7: return 4'hD;
            4'h8: return 4'hB;  4'h9: return 4'h4;  4'hA: return 4'h6;  4'hB: return 4'h3;
            4'hC: return 4'h0;  4'hD: return 4'h7;  4'hE: return 4'h9;  default: return 4'hA;
        endcase
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv_sbox(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) y[(16*j) % 63] = x[j];
        y[63] = x[63];
        return y;
    endfunction

    function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int j = 0; j < 63; j++) y[j] = x[(16*j) % 63];
        y[63] = x[63];
        return y;
    endfunction

    // Rotate left by 61 is the same as rotate right by 19.
    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ i;
        return t;
    endfunction

    function automatic logic [79:0] key_iupd(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ i;
        t[79:76]   = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    logic [1:0]  r_fsm;
    logic [1:0]  w_fsm_nxt;
    logic [63:0] r_state;
    logic [79:0] r_key;
    logic [4:0]  r_ctr;
    logic        r_dec;

    logic [79:0] w_key_fwd;
    logic [79:0] w_key_inv;
    logic [63:0] w_enc_state;
    logic [63:0] w_dec_state;
    logic        w_ctr_last;
    logic        w_ctr_first;

    assign w_key_fwd   = key_upd(r_key, r_ctr);
    assign w_key_inv   = key_iupd(r_key, r_ctr);
    assign w_enc_state = p_layer(s_layer(r_state ^ r_key[79:16]));
    assign w_dec_state = inv_s_layer(inv_p_layer(r_state)) ^ w_key_inv[79:16];
    assign w_ctr_last  = (r_ctr == c_ctr_last);
    assign w_ctr_first = (r_ctr == c_ctr_first);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_fsm <= c_st_idle;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            c_st_idle:   if (in_valid) w_fsm_nxt = in_decrypt ? c_st_keyexp : c_st_round;
            c_st_keyexp: if (w_ctr_last) w_fsm_nxt = c_st_round;
            c_st_round:  if (r_dec ? w_ctr_first : w_ctr_last) w_fsm_nxt = c_st_done;
            c_st_done:   if (out_ready) w_fsm_nxt = c_st_idle;
            default:     w_fsm_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_fsm == c_st_idle);
        out_valid = (r_fsm == c_st_done);
        busy      = (r_fsm == c_st_keyexp) || (r_fsm == c_st_round);
        round_o   = busy ? r_ctr : 5'd0;
        out_data  = r_state;
    end

    // Decrypt keeps the counter at ROUNDS across the KEYEXP->ROUND hand-off.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= '0;
            r_key   <= '0;
            r_ctr   <= '0;
            r_dec   <= 1'b0;
        end else begin
            case (r_fsm)
                c_st_idle: begin
                    if (in_valid) begin
                        r_state <= in_data;
                        r_key   <= in_key;
                        r_ctr   <= c_ctr_first;
                        r_dec   <= in_decrypt;
                    end
                end
                c_st_keyexp: begin
                    r_key <= w_key_fwd;
                    if (w_ctr_last) r_state <= r_state ^ w_key_fwd[79:16];
                    else            r_ctr   <= r_ctr + 5'd1;
                end
                c_st_round: begin
                    if (r_dec) begin
                        r_state <= w_dec_state;
                        r_key   <= w_key_inv;
                        if (!w_ctr_first) r_ctr <= r_ctr - 5'd1;
                    end else begin
                        r_key <= w_key_fwd;
                        if (w_ctr_last) begin
                            r_state <= w_enc_state ^ w_key_fwd[79:16];
                        end else begin
                            r_state <= w_enc_state;
                            r_ctr   <= r_ctr + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
